// File: rtl/ysyx_24080014_ifu.sv
// Instruction fetch unit: one AXI-lite style read per instruction, handed to the IDU over a valid/ready handshake.
// Optional feature: define YSYX_24080014_IFU_ALIGN_CHECK_EN to fault misaligned PCs without touching the bus.
module ysyx_24080014_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        busy,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  output logic        inst_valid,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_err;

  logic w_misalign;
  logic w_in_req;
  logic w_in_resp;
  logic w_in_out;

`ifdef YSYX_24080014_IFU_ALIGN_CHECK_EN
  assign w_misalign = (pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Handshake outputs are masked by rst so they drop in the same cycle reset is raised.
  assign w_in_req  = (r_state == S_REQ)  && !rst;
  assign w_in_resp = (r_state == S_RESP) && !rst;
  assign w_in_out  = (r_state == S_OUT)  && !rst;

  assign arvalid    = w_in_req && !w_misalign;
  assign araddr     = pc;
  assign rready     = w_in_resp;
  assign inst_valid = w_in_out;
  assign busy       = !(w_in_out && inst_ready);
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_err   = r_inst_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_inst     <= 32'h0;
      r_inst_pc  <= RESET_PC;
      r_inst_err <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_misalign) begin
            r_inst     <= 32'h0;
            r_inst_err <= 1'b1;
            r_inst_pc  <= pc;
            r_state    <= S_OUT;
          end else if (arready) begin
            r_inst_pc <= pc;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (rvalid) begin
            // A faulted fetch never exposes bus data to decode.
            r_inst     <= (rresp == 2'b00) ? rdata : 32'h0;
            r_inst_err <= (rresp != 2'b00);
            r_state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (inst_ready) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: doc/ysyx_24080014_ifu.md
YSYX_24080014_IFU -- requirements
Module: ysyx_24080014_ifu

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h8000_0000, which is the address of the first fetch after reset; it SHALL match the PC register reset value.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, which is a synchronous active-high reset.
REQ-004 The module SHALL have port pc, input, 32, the current PC from the PC register.
REQ-005 The module SHALL have port busy, output, 1, the PC hold: PC register loads next_pc only when busy=0.
REQ-006 The module SHALL have port araddr, output, 32, the read address.
REQ-007 The module SHALL have port arvalid/arready, out/in, 1 each, the read-address handshake.
REQ-008 The module SHALL have port rdata, input, 32, the read data.
REQ-009 The module SHALL have port rresp, input, 2, the read response, where 2'b00=OKAY and any other value is an error.
REQ-010 The module SHALL have port rvalid/rready, in/out, 1 each, the read-data handshake.
REQ-011 The module SHALL have port inst, output, 32, the fetched instruction to IDU.
REQ-012 The module SHALL have port inst_pc, output, 32, the address inst was fetched from.
REQ-013 The module SHALL have port inst_err, output, 1, which flags a fetch fault on the presented instruction.
REQ-014 The module SHALL have port inst_valid/inst_ready, out/in, 1 each, the IDU handshake.

Function
REQ-015 The module SHALL implement a three-state FSM: S_REQ, S_RESP, S_OUT.
REQ-016 In S_REQ: arvalid=1 and araddr=pc; on arvalid&&arready, latch pc into inst_pc and go to S_RESP; arvalid SHALL stay high and araddr stable until accepted.
REQ-017 In S_RESP: rready=1; on rvalid, latch rdata into inst and set inst_err=(rresp!=0), then go to S_OUT; with rresp!=0, inst SHALL be 32'h0.
REQ-018 In S_OUT: inst_valid=1 with inst/inst_pc/inst_err held stable until inst_ready; on inst_valid&&inst_ready, go to S_REQ.
REQ-019 busy SHALL be 0 only in the cycle inst_valid&&inst_ready is true, and 1 in all other cycles, so that the PC advances exactly once per delivered instruction.
REQ-020 The fetch following a handshake SHALL use the updated pc, at most one cycle after the handshake.
REQ-021 arvalid and rready SHALL never be high in the same cycle; at most one read SHALL be outstanding.
REQ-022 An rvalid arriving in S_REQ or S_OUT SHALL be ignored, and rready SHALL be 0 in those states.
REQ-023 When arready and rvalid arrive with zero wait, the minimum latency SHALL be S_REQ -> S_RESP -> S_OUT, giving inst_valid 2 cycles after arvalid first rises.
REQ-024 When inst_ready is held low, the FSM SHALL stay in S_OUT indefinitely with busy=1.

Reset
REQ-025 While rst=1, the FSM SHALL be in S_REQ, with arvalid=0, rready=0, inst_valid=0, busy=1, inst=0, inst_pc=RESET_PC, inst_err=0.
REQ-026 In the first cycle after rst deasserts, arvalid SHALL be 1 with araddr=pc (RESET_PC).
REQ-027 If rst asserts mid-transaction, the FSM SHALL abandon the transaction and return to reset state; a late rvalid SHALL be ignored per REQ-022.

Configuration
REQ-028 When macro YSYX_24080014_IFU_ALIGN_CHECK_EN is defined, an S_REQ with pc[1:0]!=2'b00 SHALL issue no bus read (arvalid=0) and go directly to S_OUT next cycle with inst=0, inst_err=1, inst_pc=pc.
REQ-029 When YSYX_24080014_IFU_ALIGN_CHECK_EN is undefined, no alignment check SHALL be performed and araddr=pc is issued unmodified.

Verification
REQ-030 The bench SHALL cover this scenario: Reset, then arready=1 and rvalid=1 with rdata=32'h0000_0413 and rresp=0 at zero wait, inst_ready=1 -> araddr=32'h8000_0000, inst=32'h0000_0413 and inst_pc=32'h8000_0000 two cycles later, and busy=0 for exactly one cycle.
REQ-031 The bench SHALL cover this scenario: arready delayed 3 cycles -> arvalid high with araddr constant for 4 cycles, and busy=1 throughout.
REQ-032 The bench SHALL cover this scenario: inst_ready low for 5 cycles in S_OUT -> inst, inst_pc and inst_valid stable, busy=1, no new arvalid.
REQ-033 The bench SHALL cover this scenario: rresp=2'b10 -> inst=0, inst_err=1; the next fetch proceeds at next_pc after the handshake.
REQ-034 The bench SHALL cover this scenario: rst asserted while in S_RESP, with a stray rvalid the cycle after deassert -> rvalid ignored, and a fresh fetch issued at 32'h8000_0000.
REQ-035 The bench SHALL cover this scenario: with YSYX_24080014_IFU_ALIGN_CHECK_EN defined, pc=32'h8000_0002 -> no arvalid, then inst_valid=1 with inst_err=1 and inst_pc=32'h8000_0002 the next cycle.
